// File: rtl/mem_ctrl_arb.sv
// Byte-serial memory bus controller: arbitrates icache line fills against LSB
// loads/stores, holds IO stores while the UART buffer is full, aborts fetches on flush.
module mem_ctrl_arb #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int IO_SEL_HI  = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    flush,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic                    if_done,
  output logic [LINE_BYTES*8-1:0] if_data,
  input  logic                    ls_req,
  input  logic                    ls_wr,
  input  logic [ADDR_W-1:0]       ls_addr,
  input  logic [1:0]              ls_size,
  input  logic [31:0]             ls_wdata,
  output logic                    ls_done,
  output logic [31:0]             ls_rdata
);

  localparam int CW = $clog2(LINE_BYTES) + 1;

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n, len, len_n, next_idx, cap_idx, ls_len;
  logic [ADDR_W-1:0]       base, base_n, mem_a_n;
  logic [7:0]              mem_dout_n;
  logic                    mem_wr_n, if_done_n, ls_done_n, ls_io;
  logic [LINE_BYTES*8-1:0] if_data_n;
  logic [31:0]             ls_rdata_n, ld_buf, ld_buf_n, wdata, wdata_n, ld_last, wshift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      base     <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
      ld_buf   <= '0;
      wdata    <= '0;
    end else if (rdy) begin
      state    <= state_n;
      cnt      <= cnt_n;
      len      <= len_n;
      base     <= base_n;
      mem_a    <= mem_a_n;
      mem_dout <= mem_dout_n;
      mem_wr   <= mem_wr_n;
      if_done  <= if_done_n;
      ls_done  <= ls_done_n;
      if_data  <= if_data_n;
      ls_rdata <= ls_rdata_n;
      ld_buf   <= ld_buf_n;
      wdata    <= wdata_n;
    end
  end

  // Byte i is issued while cnt==i and captured two edges later, i.e. when cnt==i+1.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    len_n      = len;
    base_n     = base;
    mem_a_n    = mem_a;
    mem_dout_n = mem_dout;
    mem_wr_n   = mem_wr;
    if_done_n  = 1'b0;
    ls_done_n  = 1'b0;
    if_data_n  = if_data;
    ls_rdata_n = ls_rdata;
    ld_buf_n   = ld_buf;
    wdata_n    = wdata;
    next_idx   = cnt + CW'(1);
    cap_idx    = cnt - CW'(1);
    ld_last    = {24'b0, mem_din} << {cap_idx[1:0], 3'b000};
    wshift     = wdata >> {next_idx[1:0], 3'b000};
    ls_io      = (ls_addr[IO_SEL_HI:IO_SEL_HI-1] == 2'b11);
    ls_len     = (ls_size == 2'd0) ? CW'(1) : (ls_size == 2'd1) ? CW'(2) : CW'(4);

    case (state)
      IDLE: begin
        mem_wr_n = 1'b0;
        mem_a_n  = '0;
        if (!if_done && !ls_done) begin
          if (ls_req && !(ls_wr && ls_io && io_buffer_full)) begin
            base_n   = ls_addr;
            len_n    = ls_len;
            cnt_n    = '0;
            mem_a_n  = ls_addr;
            ld_buf_n = '0;
            wdata_n  = ls_wdata;
            if (ls_wr) begin
              state_n    = STORE;
              mem_dout_n = ls_wdata[7:0];
              mem_wr_n   = 1'b1;
            end else begin
              state_n = LOAD;
            end
          end else if (if_req && !flush) begin
            base_n  = if_addr;
            len_n   = CW'(LINE_BYTES);
            cnt_n   = '0;
            mem_a_n = if_addr;
            state_n = IFETCH;
          end
        end
      end

      IFETCH: begin
        if (flush) begin
          state_n = IDLE;
          mem_a_n = '0;
          cnt_n   = '0;
        end else begin
          cnt_n   = next_idx;
          mem_a_n = (next_idx < len) ? base + ADDR_W'(next_idx) : '0;
          for (int i = 0; i < LINE_BYTES; i++) begin
            if (cnt != '0 && cap_idx == CW'(i)) if_data_n[8*i +: 8] = mem_din;
          end
          if (cnt == len) begin
            state_n   = IDLE;
            if_done_n = 1'b1;
            cnt_n     = '0;
          end
        end
      end

      LOAD: begin
        cnt_n   = next_idx;
        mem_a_n = (next_idx < len) ? base + ADDR_W'(next_idx) : '0;
        if (cnt == len) begin
          ls_rdata_n = ld_buf | ld_last;
          ls_done_n  = 1'b1;
          state_n    = IDLE;
          cnt_n      = '0;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (cnt != '0 && cap_idx == CW'(i)) ld_buf_n[8*i +: 8] = mem_din;
          end
        end
      end

      STORE: begin
        if (next_idx < len) begin
          cnt_n      = next_idx;
          mem_a_n    = base + ADDR_W'(next_idx);
          mem_dout_n = wshift[7:0];
          mem_wr_n   = 1'b1;
        end else begin
          cnt_n     = '0;
          mem_a_n   = '0;
          mem_wr_n  = 1'b0;
          ls_done_n = 1'b1;
          state_n   = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Scoreboard bench for mem_ctrl_arb: directed stimulus pushes expectations, a
// negedge monitor pops and compares whenever if_done/ls_done pulses.
module tb_mem_ctrl_arb;

  logic         clk = 1'b0;
  logic         rst, rdy, io_buffer_full, flush;
  logic [7:0]   mem_din = 8'h00;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         if_req, if_done, ls_req, ls_wr, ls_done;
  logic [31:0]  if_addr, ls_addr, ls_wdata, ls_rdata;
  logic [511:0] if_data;
  logic [1:0]   ls_size;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    int           nbytes;
    logic [31:0]  word;
    logic [511:0] line;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [int unsigned];
  int         n_checks = 0;
  int         n_pass = 0;
  int         wr_cycles = 0;
  int         cyc;
  logic [31:0] a_hold;

  mem_ctrl_arb dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;

  // Unwritten RAM reads back the low address byte, so RAM[0x1000+i] == i.
  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a[7:0];
  endfunction

  // One-cycle read latency; the bus freezes together with the controller.
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) mem[mem_a] = mem_dout;
      mem_din <= rd(mem_a);
    end
  end

  always @(negedge clk) if (mem_wr === 1'b1) wr_cycles++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mkExp(input int kind, input logic [31:0] addr,
                                 input logic [1:0] size, input logic [31:0] data);
    exp_t e;
    e.kind   = kind;
    e.addr   = addr;
    e.nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e.word   = (e.nbytes == 4) ? data : data & ((32'h1 << (8 * e.nbytes)) - 32'h1);
    e.line   = '0;
    if (kind == 0) for (int i = 0; i < 64; i++) e.line[8*i +: 8] = rd(addr + 32'(i));
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] got;
    if (if_done === 1'b1) begin
      if (sb.size() == 0) checkOutput("unexpected if_done", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        n_checks++;
        if (e.kind == 0 && if_data === e.line) n_pass++;
        else $display("[TB] FAIL ifetch 0x%0h: kind %0d, got line 0x%0h, expected 0x%0h",
                      e.addr, e.kind, if_data, e.line);
      end
    end
    if (ls_done === 1'b1) begin
      if (sb.size() == 0) checkOutput("unexpected ls_done", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        if (e.kind == 1) checkOutput($sformatf("load 0x%0h", e.addr), 64'(ls_rdata), 64'(e.word));
        else if (e.kind == 2) begin
          got = '0;
          for (int i = 0; i < e.nbytes; i++) got[8*i +: 8] = rd(e.addr + 32'(i));
          checkOutput($sformatf("store 0x%0h", e.addr), 64'(got), 64'(e.word));
        end else checkOutput("ls_done while ifetch expected", 64'd1, 64'd0);
      end
    end
  end

  task automatic waitFor(input string name, input bit want_if, input int maxc, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(want_if ? if_done === 1'b1 : ls_done === 1'b1) && n < maxc);
    if (n >= maxc) checkOutput({name, " timeout"}, 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // kind 0 = ifetch, 1 = load (data is the expected word), 2 = store (data is wdata)
  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [1:0] size,
                               input logic [31:0] data, output int n);
    sb.push_back(mkExp(kind, addr, size, data));
    if (kind == 0) begin
      if_req = 1'b1; if_addr = addr;
      waitFor("ifetch", 1'b1, 200, n);
      if_req = 1'b0;
    end else begin
      ls_req = 1'b1; ls_wr = (kind == 2); ls_addr = addr; ls_size = size; ls_wdata = data;
      waitFor("ls", 1'b0, 200, n);
      ls_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wr = 1'b0;
    ls_addr = '0; ls_size = '0; ls_wdata = '0;
    idle(3);
    checkOutput("reset mem_a", 64'(mem_a), 64'd0);
    checkOutput("reset mem_dout", 64'(mem_dout), 64'd0);
    checkOutput("reset mem_wr", 64'(mem_wr), 64'd0);
    checkOutput("reset if_done", 64'(if_done), 64'd0);
    checkOutput("reset ls_done", 64'(ls_done), 64'd0);
    checkOutput("reset ls_rdata", 64'(ls_rdata), 64'd0);
    rst = 1'b0;
    idle(1);

    // 1: full line fill
    applyStimulus(0, 32'h1000, 2'd0, 32'h0, cyc);
    checkOutput("T1 if_done latency", 64'(cyc - 1), 64'd65);
    checkOutput("T1 byte 0", 64'(if_data[7:0]), 64'd0);
    checkOutput("T1 byte 20", 64'(if_data[167:160]), 64'd20);
    checkOutput("T1 byte 63", 64'(if_data[511:504]), 64'd63);
    idle(1);

    // 2: simultaneous requests, load wins
    sb.push_back(mkExp(1, 32'h100, 2'd1, 32'h0000_0100));
    sb.push_back(mkExp(0, 32'h2000, 2'd0, 32'h0));
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h100; ls_size = 2'd1;
    if_req = 1'b1; if_addr = 32'h2000;
    waitFor("T2 load", 1'b0, 200, cyc);
    ls_req = 1'b0;
    checkOutput("T2 load latency", 64'(cyc - 1), 64'd3);
    idle(1);
    checkOutput("T2 ifetch held off", 64'(mem_a), 64'd0);
    waitFor("T2 ifetch", 1'b1, 200, cyc);
    if_req = 1'b0;
    checkOutput("T2 ls_done to if_done", 64'(cyc + 1), 64'd67);
    idle(1);

    // 3: word store, then sub-word and size-3 loads
    wr_cycles = 0;
    applyStimulus(2, 32'h200, 2'd2, 32'hDEAD_BEEF, cyc);
    checkOutput("T3 store latency", 64'(cyc - 1), 64'd4);
    checkOutput("T3 mem_wr cycles", 64'(wr_cycles), 64'd4);
    idle(1);
    applyStimulus(1, 32'h202, 2'd1, 32'h0000_DEAD, cyc);
    idle(1);
    applyStimulus(1, 32'h203, 2'd0, 32'h0000_00DE, cyc);
    idle(1);
    applyStimulus(1, 32'h200, 2'd3, 32'hDEAD_BEEF, cyc);
    idle(1);

    // 4: IO store stalls on full buffer, ifetch served meanwhile
    io_buffer_full = 1'b1; wr_cycles = 0;
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h3_0000; ls_size = 2'd0; ls_wdata = 32'h5A;
    idle(10);
    checkOutput("T4 no write while full", 64'(wr_cycles), 64'd0);
    sb.push_back(mkExp(0, 32'h4000, 2'd0, 32'h0));
    if_req = 1'b1; if_addr = 32'h4000;
    waitFor("T4 ifetch", 1'b1, 200, cyc);
    if_req = 1'b0;
    idle(3);
    checkOutput("T4 still no write", 64'(wr_cycles), 64'd0);
    sb.push_back(mkExp(2, 32'h3_0000, 2'd0, 32'h5A));
    io_buffer_full = 1'b0;
    idle(1);
    checkOutput("T4 mem_wr after drop", 64'(mem_wr), 64'd1);
    checkOutput("T4 mem_a after drop", 64'(mem_a), 64'h3_0000);
    checkOutput("T4 mem_dout", 64'(mem_dout), 64'h5A);
    waitFor("T4 store", 1'b0, 20, cyc);
    ls_req = 1'b0;
    checkOutput("T4 one write", 64'(wr_cycles), 64'd1);
    idle(1);

    // 5: flush at byte 20, flush in IDLE blocks accept, then full refetch
    if_req = 1'b1; if_addr = 32'h3000;
    cyc = 0;
    do begin idle(1); cyc++; end while (mem_a !== 32'h3014 && cyc < 100);
    checkOutput("T5 reached byte 20", 64'(mem_a), 64'h3014);
    flush = 1'b1;
    idle(1);
    checkOutput("T5 mem_a after flush", 64'(mem_a), 64'd0);
    checkOutput("T5 no if_done", 64'(if_done), 64'd0);
    idle(1);
    checkOutput("T5 flush blocks accept", 64'(mem_a), 64'd0);
    flush = 1'b0;
    applyStimulus(0, 32'h3000, 2'd0, 32'h0, cyc);
    checkOutput("T5 refetch latency", 64'(cyc - 1), 64'd65);
    idle(1);

    // 6: stall mid-load, then reset mid-ifetch
    sb.push_back(mkExp(1, 32'h100, 2'd2, 32'h0302_0100));
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h100; ls_size = 2'd2;
    idle(3);
    a_hold = mem_a;
    rdy = 1'b0;
    idle(5);
    checkOutput("T6 mem_a frozen", 64'(mem_a), 64'(a_hold));
    checkOutput("T6 ls_rdata held", 64'(ls_rdata), 64'hDEAD_BEEF);
    rdy = 1'b1;
    waitFor("T6 load", 1'b0, 50, cyc);
    ls_req = 1'b0;
    idle(1);
    if_req = 1'b1; if_addr = 32'h1000;
    idle(10);
    rst = 1'b1; if_req = 1'b0;
    idle(1);
    rst = 1'b0;
    checkOutput("T6 rst mem_a", 64'(mem_a), 64'd0);
    checkOutput("T6 rst mem_wr", 64'(mem_wr), 64'd0);
    checkOutput("T6 rst mem_dout", 64'(mem_dout), 64'd0);
    checkOutput("T6 rst ls_rdata", 64'(ls_rdata), 64'd0);
    checkOutput("T6 rst if_data", 64'(|if_data), 64'd0);
    checkOutput("T6 rst dones", 64'({if_done, ls_done}), 64'd0);
    applyStimulus(0, 32'h1000, 2'd0, 32'h0, cyc);
    checkOutput("T6 fetch after rst", 64'(cyc - 1), 64'd65);
    idle(2);

    checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
